// File: rtl/hash_sched_pkg.sv
// Shared state type, data widths and nonce range helper for the nonce scheduler.
package hash_sched_pkg;

    localparam int NONCE_W = 32;
    localparam int H0_W    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_SCAN,
        S_FINISH
    } sched_state_t;

    // Sum is 33 bits wide so a nonce that wraps past 0xFFFFFFFF never counts as in range.
    function automatic logic inRange(input logic [NONCE_W-1:0] base,
                                     input logic [NONCE_W-1:0] offset,
                                     input logic [NONCE_W-1:0] last);
        return ({1'b0, base} + {1'b0, offset}) <= {1'b0, last};
    endfunction

endpackage

// File: rtl/h0_target_cmp.sv
// Registers the lane-valid flag and lane index alongside the 1-cycle core read,
// then compares the returned H0 against the target.
module h0_target_cmp
    import hash_sched_pkg::*;
#(
    parameter int IDXW = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               laneEn_i,
    input  logic [IDXW-1:0]    laneIdx_i,
    input  logic [NONCE_W-1:0] base_i,
    input  logic [NONCE_W-1:0] last_i,
    input  logic [H0_W-1:0]    target_i,
    input  logic [H0_W-1:0]    rdData_i,
    output logic               hit_o,
    output logic [IDXW-1:0]    hitIdx_o
);

    logic            valid_q;
    logic [IDXW-1:0] idx_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= laneEn_i && inRange(base_i, NONCE_W'(laneIdx_i), last_i);
            idx_q   <= laneIdx_i;
        end
    end

    assign hit_o    = valid_q && (rdData_i < target_i);
    assign hitIdx_o = idx_q;

endmodule

// File: rtl/hash_nonce_scheduler.sv
// Batch sweep controller for a multi-nonce SHA-256 core: launch, wait, scan H0 lanes, stop on hit.
// Optional core_done watchdog and timeout port are enabled by defining SCHED_TIMEOUT_EN.
module hash_nonce_scheduler
    import hash_sched_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int IDXW       = $clog2(NUM_NONCES)
`ifdef SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [NONCE_W-1:0] nonce_first_i,
    input  logic [NONCE_W-1:0] nonce_last_i,
    input  logic [H0_W-1:0]    target_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               found_o,
    output logic [NONCE_W-1:0] found_nonce_o,
    output logic [31:0]        batches_o,
`ifdef SCHED_TIMEOUT_EN
    output logic               timeout_o,
`endif
    output logic               core_start_o,
    output logic [NONCE_W-1:0] core_nonce_base_o,
    input  logic               core_done_i,
    output logic [IDXW-1:0]    core_rd_idx_o,
    input  logic [H0_W-1:0]    core_rd_data_i
);

    sched_state_t       state_q, state_d;
    logic [NONCE_W-1:0] base_q, base_d;
    logic [NONCE_W-1:0] last_q, last_d;
    logic [H0_W-1:0]    target_q, target_d;
    logic               found_q, found_d;
    logic [NONCE_W-1:0] foundNonce_q, foundNonce_d;
    logic [31:0]        batches_q, batches_d;
    logic [IDXW:0]      scanCnt_q, scanCnt_d;
    logic               abortPend_q, abortPend_d;
    logic               busy_q, done_q, coreStart_q;
    logic               hit;
    logic [IDXW-1:0]    hitIdx;
    logic               laneEn;

`ifdef SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic             timeout_q, timeout_d;
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
`endif

    // scanCnt MSB marks the extra cycle that compares the last lane after all reads are issued.
    assign laneEn = (state_q == S_SCAN) && !scanCnt_q[IDXW];

    h0_target_cmp #(
        .IDXW(IDXW)
    ) u_cmp (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .laneEn_i (laneEn),
        .laneIdx_i(scanCnt_q[IDXW-1:0]),
        .base_i   (base_q),
        .last_i   (last_q),
        .target_i (target_q),
        .rdData_i (core_rd_data_i),
        .hit_o    (hit),
        .hitIdx_o (hitIdx)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        last_d       = last_q;
        target_d     = target_q;
        found_d      = found_q;
        foundNonce_d = foundNonce_q;
        batches_d    = batches_q;
        scanCnt_d    = scanCnt_q;
        abortPend_d  = abortPend_q;
`ifdef SCHED_TIMEOUT_EN
        timeout_d    = timeout_q;
        tmoCnt_d     = tmoCnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d       = nonce_first_i;
                    last_d       = nonce_last_i;
                    target_d     = target_i;
                    found_d      = 1'b0;
                    foundNonce_d = '0;
                    batches_d    = '0;
                    abortPend_d  = 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    timeout_d    = 1'b0;
`endif
                    state_d      = (nonce_first_i > nonce_last_i) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                batches_d = batches_q + 32'd1;
                scanCnt_d = '0;
`ifdef SCHED_TIMEOUT_EN
                tmoCnt_d  = '0;
`endif
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // An abort here only takes effect once the current batch has been scanned.
                abortPend_d = abortPend_q || abort_i;
                if (core_done_i) begin
                    scanCnt_d = '0;
                    state_d   = S_SCAN;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    found_d   = 1'b0;
                    state_d   = S_FINISH;
                end else begin
                    tmoCnt_d = tmoCnt_q + TMO_W'(1);
                end
`endif
            end
            S_SCAN: begin
                if (hit) begin
                    found_d      = 1'b1;
                    foundNonce_d = base_q + NONCE_W'(hitIdx);
                    state_d      = S_FINISH;
                end else if (abort_i) begin
                    state_d = S_FINISH;
                end else if (scanCnt_q[IDXW]) begin
                    if (abortPend_q || !inRange(base_q, NONCE_W'(NUM_NONCES), last_q)) begin
                        state_d = S_FINISH;
                    end else begin
                        base_d  = base_q + NONCE_W'(NUM_NONCES);
                        state_d = S_LAUNCH;
                    end
                end else begin
                    scanCnt_d = scanCnt_q + (IDXW+1)'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are computed from the next state so every output comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            last_q       <= '0;
            target_q     <= '0;
            found_q      <= 1'b0;
            foundNonce_q <= '0;
            batches_q    <= '0;
            scanCnt_q    <= '0;
            abortPend_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coreStart_q  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            timeout_q    <= 1'b0;
            tmoCnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            last_q       <= last_d;
            target_q     <= target_d;
            found_q      <= found_d;
            foundNonce_q <= foundNonce_d;
            batches_q    <= batches_d;
            scanCnt_q    <= scanCnt_d;
            abortPend_q  <= abortPend_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_FINISH);
            coreStart_q  <= (state_d == S_LAUNCH);
`ifdef SCHED_TIMEOUT_EN
            timeout_q    <= timeout_d;
            tmoCnt_q     <= tmoCnt_d;
`endif
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign found_o           = found_q;
    assign found_nonce_o     = foundNonce_q;
    assign batches_o         = batches_q;
    assign core_start_o      = coreStart_q;
    assign core_nonce_base_o = base_q;
    assign core_rd_idx_o     = scanCnt_q[IDXW-1:0];
`ifdef SCHED_TIMEOUT_EN
    assign timeout_o         = timeout_q;
`endif

endmodule

// File: doc/hash_nonce_scheduler.md
# hash_nonce_scheduler

Sequencing controller for a multi-nonce SHA-256 bitcoin hash core that evaluates `NUM_NONCES` nonces per run. It sweeps a caller-supplied nonce range in batches: it launches the core, waits for completion, scans the per-nonce H0 results against a target, and stops on the first hit or when the range is exhausted. It sits between the mining host/testbench control logic and the hash core.

## Interface
- `NUM_NONCES`, 16: nonces evaluated per core run; must be a power of two.
- `IDXW`, `$clog2(NUM_NONCES)`: width of the result index.
- `TIMEOUT_CYCLES`, 4096: watchdog limit for `core_done`; only used when `SCHED_TIMEOUT_EN` is defined.
- `clk`  in  1  Single clock for all logic.
- `reset`  in  1  Reset is synchronous and active-high.
- `start`  in  1  Begin a sweep; sampled only in IDLE.
- `abort`  in  1  Stop the sweep early; level input.
- `nonce_first`  in  32  First nonce of the range (inclusive); sampled with `start`.
- `nonce_last`  in  32  Last nonce of the range (inclusive); sampled with `start`.
- `target`  in  32  Hit condition is `h0 < target` (unsigned); sampled with `start`.
- `busy`  out  1  High in every state except IDLE.
- `done`  out  1  One-cycle pulse when a sweep ends.
- `found`  out  1  Hit flag; valid from `done` until the next accepted `start`.
- `found_nonce`  out  32  Winning nonce.
- `batches`  out  32  Number of core runs issued in this sweep.
- `timeout`  out  1  Watchdog fired; present only when `SCHED_TIMEOUT_EN` is defined.
- `core_start`  out  1  One-cycle launch pulse to the core.
- `core_nonce_base`  out  32  Nonce of core lane 0; lane i hashes base+i. Held stable from LAUNCH through SCAN.
- `core_done`  in  1  Core completion pulse.
- `core_rd_idx`  out  IDXW  Result lane select.
- `core_rd_data`  in  32  Final H0 of the lane selected by `core_rd_idx` on the previous cycle (1-cycle read latency).

## Operation
- FSM states: IDLE, LAUNCH, WAIT, SCAN, FINISH.
- IDLE → LAUNCH on `start`. The range and target are latched, `found`/`found_nonce`/`batches` are cleared, and base is set to `nonce_first`.
  - If `nonce_first > nonce_last`, the transition is IDLE → FINISH with `found=0` and `batches=0`; no core launch occurs.
- LAUNCH:
  - `core_start=1` for exactly this cycle.
  - `batches` increments.
  - Next state is WAIT.
- WAIT:
  - On `core_done`, go to SCAN with `core_rd_idx=0`.
  - `abort` sampled in WAIT is remembered; it does not leave WAIT until `core_done` arrives.
- SCAN:
  - `core_rd_idx` steps 0..NUM_NONCES-1, one lane per cycle.
  - Lane i's data is compared on the following cycle.
  - Lane i is valid only if base+i ≤ `nonce_last`, computed in 33-bit arithmetic so wrap past 0xFFFFFFFF never validates a lane.
  - The first valid lane with `core_rd_data < target` sets `found=1` and `found_nonce=base+i`, then goes to FINISH immediately; the lowest index wins.
- End of SCAN with no hit:
  - Go to FINISH if a pending abort exists, or if the 33-bit value base+NUM_NONCES > `nonce_last`.
  - Otherwise set base += NUM_NONCES and go to LAUNCH.
- FINISH: `done=1` for one cycle, then IDLE.
- `abort` in SCAN goes to FINISH on the next edge with `found=0`, unless the compare in that same cycle is a hit; a hit takes priority.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `found`, `timeout`, `core_start` = 0; `found_nonce`, `batches`, `core_nonce_base`, `core_rd_idx` = 0.
- Reset asserted mid-sweep returns to IDLE on the next edge. No `done` pulse is emitted, and the core is not signalled.
- `start` at edge k puts `core_start` high in cycle k+1.
- SCAN lasts NUM_NONCES+1 cycles when there is no hit.
- Per batch, overhead is LAUNCH(1) + core latency + SCAN(NUM_NONCES+1).
- `done` follows the last SCAN compare cycle by exactly 1 cycle.
- All outputs are registered.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT and resets on LAUNCH.
  - If it reaches `TIMEOUT_CYCLES` with no `core_done`, the FSM goes to FINISH with `timeout=1` and `found=0`.
  - `timeout` clears on the next accepted `start`.
- `SCHED_TIMEOUT_EN` undefined: the `timeout` port and counter are absent, and WAIT waits indefinitely.

## Structure
- Shared package `hash_sched_pkg`:
  - state enum `sched_state_t`
  - `NONCE_W=32`
  - `H0_W=32`
- One sub-module `h0_target_cmp`: registered lane-valid mask plus unsigned compare, producing hit and index.

## Test plan
- Range 0..15, target 0x00000001, core model returns h0=0 at lane 5 → `found=1`, `found_nonce=5`, `batches=1`, one `done` pulse.
- Range 0..47, hit only at nonce 40 → `batches=3`, `found_nonce=40`; `core_nonce_base` sequence 0, 16, 32.
- Range 0xFFFFFFF8..0xFFFFFFFF, lanes 8–15 return 0 (hits) → lanes 8–15 masked, `found=0`, `batches=1`, no wrap relaunch.
- `nonce_first=10`, `nonce_last=3` → `done` 1 cycle after `start`, `core_start` never asserted, `batches=0`.
- `abort` asserted in WAIT of batch 1 for range 0..63 with no hits → `done` after that batch's SCAN, `batches=1`, `found=0`; reset pulsed mid-SCAN of a second run → all outputs return to reset values and no `done` pulse.
- With `SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES=100`, core never responds → `timeout=1` and `done` exactly 100 cycles after entering WAIT.
